// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
//   Shared definitions for the MIPS-lite multicycle control unit:
//   FSM state encoding, opcode values, ALU-op codes handed to the
//   ALU-control decoder, datapath mux-select codes and the packed
//   control word produced by the state decoder.
package mips_ctrl_pkg;

  // 4-bit state encoding; codes 14 and 15 are unused and recover to S_RST.
  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    REXEC  = 4'd7,
    RWB    = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    IEXEC  = 4'd11,
    IWB    = 4'd12,
    NEXEC  = 4'd13
  } state_t;

  // Opcodes (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_NORI  = 6'b001110;

  // ALU-op codes understood by the ALU-control decoder.
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_NORI  = 3'b011;
  localparam logic [2:0] ALUOP_RSVD  = 3'b100;

  // ALU B-operand select.
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC select.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Complete set of datapath controls for one cycle.
  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

endpackage : mips_ctrl_pkg

// File: rtl/multicycle_ctrl_outdec.sv
// ctrl_outdec
//   Combinational state -> control-word decoder for multicycle_ctrl.
//   Every output is a function of the state alone, except the FETCH-cycle
//   IR/PC load strobes, which are qualified by mem_ready so the IR and PC
//   only update on the cycle the instruction read actually completes.
// Ports
//   state     in  4  current FSM state
//   mem_ready in  1  memory completes the current access this cycle
//   ctrl      out    packed control word (see mips_ctrl_pkg::ctrl_t)
module ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memread  = 1'b1;
        ctrl.alusrcb  = SRCB_FOUR;
        ctrl.aluop    = ALUOP_ADD;
        ctrl.pcsource = PCSRC_ALU;
        ctrl.irwrite  = mem_ready;
        ctrl.pcwrite  = mem_ready;
      end
      DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        ctrl.alusrcb = SRCB_IMM_SH2;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regdst   = 1'b0;
      end
      MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      REXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REG;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      RWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        ctrl.memtoreg = 1'b0;
      end
      BRANCH: begin
        ctrl.alusrca     = 1'b1;
        ctrl.alusrcb     = SRCB_REG;
        ctrl.aluop       = ALUOP_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PCSRC_ALUOUT;
      end
      JUMP: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCSRC_JUMP;
      end
      IEXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      NEXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_NORI;
      end
      IWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b0;
        ctrl.memtoreg = 1'b0;
      end
      default: ctrl = '0;  // S_RST and unused encodings drive nothing
    endcase
  end

endmodule : ctrl_outdec

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Moore control FSM for the MIPS-lite multicycle datapath. Steps one
//   instruction at a time through fetch, decode and execute states, holding
//   the memory states until mem_ready, and flags unknown opcodes with a
//   one-cycle registered illegal pulse.
// Ports
//   clk         in  1  rising-edge clock
//   reset       in  1  synchronous, active-high reset
//   op          in  6  opcode field IR[31:26]
//   mem_ready   in  1  memory completes current access this cycle
//   pcwrite     out 1  unconditional PC load
//   pcwritecond out 1  PC load if ALU zero (beq)
//   iord        out 1  memory address: 0 PC, 1 ALUOut
//   memread     out 1  memory read request
//   memwrite    out 1  memory write request
//   irwrite     out 1  IR load
//   memtoreg    out 1  reg write data: 0 ALUOut, 1 MDR
//   regdst      out 1  dest reg: 0 rt, 1 rd
//   regwrite    out 1  register file write enable
//   alusrca     out 1  ALU A: 0 PC, 1 reg A
//   alusrcb     out 2  ALU B: B / 4 / imm / imm<<2
//   aluop       out 3  ALU-op code to ALU-control decoder
//   pcsource    out 2  next PC: ALU / ALUOut / jump target
//   illegal     out 1  one-cycle pulse on unknown opcode
//   state       out 4  current state (debug)
module multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] aluop,
  output logic [1:0] pcsource,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  ctrl_t  ctrl;

  // State register and illegal-opcode flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RST;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic. op is only looked at in DECODE and MEMADR, mem_ready
  // only in the three memory-access states.
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      S_RST:  state_d = FETCH;
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_RTYPE:     state_d = REXEC;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = IEXEC;
          OP_NORI:      state_d = NEXEC;
          default: begin
            // Abandon the instruction; flag it in the next cycle.
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        if (op == OP_LW)      state_d = MEMRD;
        else if (op == OP_SW) state_d = MEMWR;
        else                  state_d = FETCH;  // IR is stable, so unreachable
      end
      MEMRD:  if (mem_ready) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (mem_ready) state_d = FETCH;
      REXEC:  state_d = RWB;
      RWB:    state_d = FETCH;
      BRANCH: state_d = FETCH;
      JUMP:   state_d = FETCH;
      IEXEC:  state_d = IWB;
      NEXEC:  state_d = IWB;
      IWB:    state_d = FETCH;
      default: state_d = S_RST;
    endcase
  end

  ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pcwrite     = ctrl.pcwrite;
  assign pcwritecond = ctrl.pcwritecond;
  assign iord        = ctrl.iord;
  assign memread     = ctrl.memread;
  assign memwrite    = ctrl.memwrite;
  assign irwrite     = ctrl.irwrite;
  assign memtoreg    = ctrl.memtoreg;
  assign regdst      = ctrl.regdst;
  assign regwrite    = ctrl.regwrite;
  assign alusrca     = ctrl.alusrca;
  assign alusrcb     = ctrl.alusrcb;
  assign aluop       = ctrl.aluop;
  assign pcsource    = ctrl.pcsource;
  assign illegal     = illegal_q;
  assign state       = state_q;

endmodule : multicycle_ctrl

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a cycle-by-cycle vector table
// (inputs for the cycle plus the state, control word and illegal flag
// expected in that cycle) followed by FETCH-to-FETCH latency measurements.
module tb_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsource;
  logic [2:0] aluop;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .mem_ready   (mem_ready),
    .pcwrite     (pcwrite),
    .pcwritecond (pcwritecond),
    .iord        (iord),
    .memread     (memread),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .memtoreg    (memtoreg),
    .regdst      (regdst),
    .regwrite    (regwrite),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .aluop       (aluop),
    .pcsource    (pcsource),
    .illegal     (illegal),
    .state       (state)
  );

  // Observed control word; flag order:
  // pcwrite pcwritecond iord memread memwrite irwrite memtoreg regdst regwrite alusrca
  logic [16:0] act_w;
  assign act_w = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                  memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource};

  // Expected control words: {flags, alusrcb, aluop, pcsource}
  localparam logic [16:0] W_ZERO    = 17'd0;
  localparam logic [16:0] W_FETCH_R = {10'b1001010000, 2'b01, 3'b000, 2'b00};
  localparam logic [16:0] W_FETCH_W = {10'b0001000000, 2'b01, 3'b000, 2'b00};
  localparam logic [16:0] W_DECODE  = {10'b0000000000, 2'b11, 3'b000, 2'b00};
  localparam logic [16:0] W_MEMADR  = {10'b0000000001, 2'b10, 3'b000, 2'b00};
  localparam logic [16:0] W_MEMRD   = {10'b0011000000, 2'b00, 3'b000, 2'b00};
  localparam logic [16:0] W_MEMWB   = {10'b0000001010, 2'b00, 3'b000, 2'b00};
  localparam logic [16:0] W_MEMWR   = {10'b0010100000, 2'b00, 3'b000, 2'b00};
  localparam logic [16:0] W_REXEC   = {10'b0000000001, 2'b00, 3'b010, 2'b00};
  localparam logic [16:0] W_RWB     = {10'b0000000110, 2'b00, 3'b000, 2'b00};
  localparam logic [16:0] W_BRANCH  = {10'b0100000001, 2'b00, 3'b001, 2'b01};
  localparam logic [16:0] W_JUMP    = {10'b1000000000, 2'b00, 3'b000, 2'b10};
  localparam logic [16:0] W_IEXEC   = {10'b0000000001, 2'b10, 3'b000, 2'b00};
  localparam logic [16:0] W_NEXEC   = {10'b0000000001, 2'b10, 3'b011, 2'b00};
  localparam logic [16:0] W_IWB     = {10'b0000000010, 2'b00, 3'b000, 2'b00};

  localparam logic [5:0] OPX = 6'b111111;  // don't-care / unknown opcode

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [16:0] w;
    logic        ill;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic r, input logic [5:0] o, input logic m,
                     input state_t s, input logic [16:0] w, input logic il);
    vec_t v;
    v.rst = r; v.op = o; v.mr = m; v.st = s; v.w = w; v.ill = il;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reset, then count cycles from the first FETCH until FETCH recurs,
  // with mem_ready tied high.
  task automatic measure(input logic [5:0] o, input int exp_n, input string name);
    int n;
    bit done;
    @(negedge clk);
    reset = 1'b1; op = o; mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk({name, "_start"}, 32'(state), 32'(FETCH));
    n = 1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      if (state == FETCH) done = 1'b1;
      else n++;
    end
    if (!done) n = -1;
    chk({name, "_latency"}, 32'(n), 32'(exp_n));
    $display("[TB] latency %s: %0d cycles", name, n);
  endtask

  initial begin
    reset = 1'b1; op = OPX; mem_ready = 1'b0;

    // lw, all memory ready
    add(0, OPX,      1, S_RST,  W_ZERO,    0);
    add(0, OPX,      1, FETCH,  W_FETCH_R, 0);
    add(0, OP_LW,    1, DECODE, W_DECODE,  0);
    add(0, OP_LW,    1, MEMADR, W_MEMADR,  0);
    add(0, OPX,      1, MEMRD,  W_MEMRD,   0);
    add(0, OPX,      1, MEMWB,  W_MEMWB,   0);
    // R-type; mem_ready low outside memory states must not stall
    add(0, OPX,      1, FETCH,  W_FETCH_R, 0);
    add(0, OP_RTYPE, 0, DECODE, W_DECODE,  0);
    add(0, OPX,      0, REXEC,  W_REXEC,   0);
    add(0, OPX,      0, RWB,    W_RWB,     0);
    // addi
    add(0, OPX,      1, FETCH,  W_FETCH_R, 0);
    add(0, OP_ADDI,  1, DECODE, W_DECODE,  0);
    add(0, OPX,      1, IEXEC,  W_IEXEC,   0);
    add(0, OPX,      1, IWB,    W_IWB,     0);
    // nori
    add(0, OPX,      1, FETCH,  W_FETCH_R, 0);
    add(0, OP_NORI,  1, DECODE, W_DECODE,  0);
    add(0, OPX,      1, NEXEC,  W_NEXEC,   0);
    add(0, OPX,      1, IWB,    W_IWB,     0);
    // beq
    add(0, OPX,      1, FETCH,  W_FETCH_R, 0);
    add(0, OP_BEQ,   1, DECODE, W_DECODE,  0);
    add(0, OPX,      1, BRANCH, W_BRANCH,  0);
    // j
    add(0, OPX,      1, FETCH,  W_FETCH_R, 0);
    add(0, OP_J,     1, DECODE, W_DECODE,  0);
    add(0, OPX,      1, JUMP,   W_JUMP,    0);
    // unknown opcode: one-cycle illegal pulse, no write enables
    add(0, OPX,      1, FETCH,  W_FETCH_R, 0);
    add(0, OPX,      1, DECODE, W_DECODE,  0);
    add(0, OPX,      0, FETCH,  W_FETCH_W, 1);
    add(0, OPX,      0, FETCH,  W_FETCH_W, 0);
    add(0, OPX,      1, FETCH,  W_FETCH_R, 0);
    // sw with three wait cycles in MEMWR
    add(0, OP_SW,    1, DECODE, W_DECODE,  0);
    add(0, OP_SW,    1, MEMADR, W_MEMADR,  0);
    add(0, OPX,      0, MEMWR,  W_MEMWR,   0);
    add(0, OPX,      0, MEMWR,  W_MEMWR,   0);
    add(0, OPX,      0, MEMWR,  W_MEMWR,   0);
    add(0, OPX,      1, MEMWR,  W_MEMWR,   0);
    // lw interrupted by a 3-cycle reset while stalled in MEMRD
    add(0, OPX,      1, FETCH,  W_FETCH_R, 0);
    add(0, OP_LW,    1, DECODE, W_DECODE,  0);
    add(0, OP_LW,    1, MEMADR, W_MEMADR,  0);
    add(0, OPX,      0, MEMRD,  W_MEMRD,   0);
    add(1, OPX,      0, MEMRD,  W_MEMRD,   0);
    add(1, OPX,      1, S_RST,  W_ZERO,    0);
    add(1, OPX,      1, S_RST,  W_ZERO,    0);
    add(0, OPX,      1, S_RST,  W_ZERO,    0);
    add(0, OPX,      0, FETCH,  W_FETCH_W, 0);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; op = vecs[i].op; mem_ready = vecs[i].mr;
      #1;
      chk($sformatf("row%0d_state", i), 32'(state),   32'(vecs[i].st));
      chk($sformatf("row%0d_ctrl",  i), 32'(act_w),   32'(vecs[i].w));
      chk($sformatf("row%0d_ill",   i), 32'(illegal), 32'(vecs[i].ill));
      $display("[TB] row %0d rst=%0b op=%b mr=%0b state=%0d ctrl=%05h ill=%0b",
               i, vecs[i].rst, vecs[i].op, vecs[i].mr, state, act_w, illegal);
    end

    measure(OP_LW,    5, "lw");
    measure(OP_SW,    4, "sw");
    measure(OP_RTYPE, 4, "rtype");
    measure(OP_ADDI,  4, "addi");
    measure(OP_NORI,  4, "nori");
    measure(OP_BEQ,   3, "beq");
    measure(OP_J,     3, "j");
    measure(OPX,      2, "illegal");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_multicycle_ctrl
